multicycle_ctrl: RTL

- Multicycle control sequencer for the 32-bit datapath (8-bit byte-addressed PC, 4-entry register file, 256-byte data memory).
- Replaces the "everything on posedge, writeback on negedge" scheme with an explicit FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives all datapath enables and muxes, handshakes with instruction and data memory, and resolves beq/bne/j.
- Provides halt, illegal-opcode and bus-timeout reporting plus a retired-instruction counter.

---
 rtl/multicycle_ctrl_if.sv | 19 +
 rtl/multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/data memory handshake bundle
interface multicycle_ctrl_if;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_we;
  logic [1:0] dmem_size;
  logic       dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we, dmem_size,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we, dmem_size,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the 32-bit multicycle datapath
module multicycle_ctrl #(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         opcode,
  input  logic               zero,
  multicycle_ctrl_if.master  mem,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic [2:0]         alu_op,
  output logic               alu_src_imm,
  output logic               reg_dst_rd,
  output logic               reg_we,
  output logic [1:0]         wb_sel,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               bus_err,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_LUI = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_ITYPE,
    C_LOAD,
    C_LUI,
    C_STORE,
    C_BEQ,
    C_BNE,
    C_JUMP,
    C_HALT,
    C_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [5:0] op);
    if (op <= 6'd5)       return C_RTYPE;
    else if (op <= 6'd10) return C_ITYPE;
    else if (op <= 6'd13) return C_LOAD;
    else if (op == 6'd14) return C_LUI;
    else if (op <= 6'd17) return C_STORE;
    else if (op == 6'd18) return C_BEQ;
    else if (op == 6'd19) return C_BNE;
    else if (op == 6'd20) return C_JUMP;
    else if (op == 6'd63) return C_HALT;
    else                  return C_ILLEGAL;
  endfunction

  // addi/subi/andi/ori/slti map onto the R-type ALU codes, skipping nor
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      6'd6:    return ALU_ADD;
      6'd7:    return ALU_SUB;
      6'd8:    return ALU_AND;
      6'd9:    return ALU_OR;
      default: return ALU_SLT;
    endcase
  endfunction

  // byte/half/word repeats every three opcodes in both the load and store groups
  function automatic logic [1:0] access_size(input logic [5:0] op);
    case (op)
      6'd11, 6'd15: return 2'd0;
      6'd12, 6'd16: return 2'd1;
      default:      return 2'd2;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  op_class_t         cls_q;
  op_class_t         dec_cls;
  logic              wait_last;
  logic              fetch_timeout;
  logic              mem_timeout;

  assign cls_q         = classify(op_q);
  assign dec_cls       = classify(opcode);
  assign wait_last     = (wait_cnt == WAIT_LAST);
  assign fetch_timeout = (state_q == S_FETCH) && !mem.imem_ready && wait_last;
  assign mem_timeout   = (state_q == S_MEM) && !mem.dmem_ready && wait_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem.imem_ready)  state_d = S_DECODE;
        else if (wait_last) state_d = S_HALT;
      end
      S_DECODE: begin
        if (dec_cls == C_HALT || dec_cls == C_ILLEGAL) state_d = S_HALT;
        else                                           state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE:      state_d = S_MEM;
          C_BEQ, C_BNE, C_JUMP: state_d = S_FETCH;
          default:              state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.dmem_ready)  state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        else if (wait_last) state_d = S_HALT;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_we   = 1'b0;
    mem.dmem_size = 2'd0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PC_SEQ;
    alu_op        = ALU_ADD;
    alu_src_imm   = 1'b0;
    reg_dst_rd    = 1'b0;
    reg_we        = 1'b0;
    wb_sel        = WB_ALU;
    busy          = (state_q != S_IDLE) && (state_q != S_HALT);
    halted        = (state_q == S_HALT);
    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        ir_we        = mem.imem_ready;
      end
      S_EXEC: begin
        case (cls_q)
          C_RTYPE: begin
            alu_op     = op_q[2:0];
            reg_dst_rd = 1'b1;
          end
          C_ITYPE: begin
            alu_op      = imm_alu_op(op_q);
            alu_src_imm = 1'b1;
          end
          C_LOAD, C_STORE: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
          end
          C_BEQ: begin
            alu_op = ALU_SUB;
            pc_we  = 1'b1;
            pc_sel = zero ? PC_BRANCH : PC_SEQ;
          end
          C_BNE: begin
            alu_op = ALU_SUB;
            pc_we  = 1'b1;
            pc_sel = zero ? PC_SEQ : PC_BRANCH;
          end
          C_JUMP: begin
            pc_we  = 1'b1;
            pc_sel = PC_JUMP;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.dmem_req  = 1'b1;
        mem.dmem_size = access_size(op_q);
        mem.dmem_we   = (cls_q == C_STORE);
        // a store retires straight out of MEM; loads still need WB
        pc_we         = mem.dmem_ready && (cls_q == C_STORE);
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        reg_dst_rd = (cls_q == C_RTYPE);
        if (cls_q == C_LOAD)     wb_sel = WB_MEM;
        else if (cls_q == C_LUI) wb_sel = WB_LUI;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 6'd0;
    end else if (state_q == S_DECODE) begin
      op_q <= opcode;
    end
  end

  // counts consecutive not-ready cycles of the current FETCH or MEM visit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if ((state_q == S_FETCH && !mem.imem_ready) ||
                 (state_q == S_MEM && !mem.dmem_ready)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (state_q == S_DECODE && dec_cls == C_ILLEGAL) illegal <= 1'b1;
      if (fetch_timeout || mem_timeout)                bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (pc_we || (state_q == S_DECODE && dec_cls == C_HALT)) begin
      instr_count <= instr_count + COUNT_W'(1);
    end
  end

endmodule
